// File: rtl/phy_pkg.sv
// ---------------------------------------------------------------------------
// phy_pkg
// Definitions shared by the PHY receive-path blocks:
//   - clog2 / ptr_width : index-width helpers usable in parameter expressions
//   - VALID_PULSE / VALID_HOLD : lane-valid behaviour selectors
//   - PHY_DATA_W : default PHY data word width
// ---------------------------------------------------------------------------
package phy_pkg;

   localparam int VALID_PULSE = 0;
   localparam int VALID_HOLD  = 1;
   localparam int PHY_DATA_W  = 4;

   // Ceiling log2; returns 0 for values of 0 or 1.
   function automatic int clog2(input int value);
      int res;
      res = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) res = i + 1;
      end
      return res;
   endfunction

   // Lane pointer width. Never narrower than one bit, so that a single-lane
   // build still has a legal pointer vector.
   function automatic int ptr_width(input int lanes);
      return (lanes > 1) ? clog2(lanes) : 1;
   endfunction

endpackage

// File: rtl/demux1an_rr_param_if.sv
// ---------------------------------------------------------------------------
// demux1an_rr_param_if
// Bus bundle for the round-robin receive demux.
//   valid_in   : data_in carries a valid word this cycle
//   data_in    : input word (WIDTH bits)
//   align_in   : frame start, forces the lane pointer back to lane 0
//   data_out   : LANES*WIDTH bits, lane i in [i*WIDTH +: WIDTH]
//   valid_out  : per-lane valid
//   lane_ptr   : lane that the next valid word will be written to
//   frame_done : one-cycle pulse after a word was written to the last lane
// Modports: master drives the inputs (upstream / bench side), slave is the
// demux side.
// ---------------------------------------------------------------------------
interface demux1an_rr_param_if
   import phy_pkg::*;
#(
   parameter int WIDTH = PHY_DATA_W,
   parameter int LANES = 2,
   parameter int PTR_W = ptr_width(LANES)
);

   logic                   valid_in;
   logic [WIDTH-1:0]       data_in;
   logic                   align_in;
   logic [LANES*WIDTH-1:0] data_out;
   logic [LANES-1:0]       valid_out;
   logic [PTR_W-1:0]       lane_ptr;
   logic                   frame_done;

   modport master (
      output valid_in, data_in, align_in,
      input  data_out, valid_out, lane_ptr, frame_done
   );

   modport slave (
      input  valid_in, data_in, align_in,
      output data_out, valid_out, lane_ptr, frame_done
   );

endinterface

// File: rtl/demux_lane_reg.sv
// ---------------------------------------------------------------------------
// demux_lane_reg
// One output lane of the round-robin demux: a WIDTH-bit data register and
// its valid flag.
//   clk_4f     : clock, rising edge
//   reset_L    : synchronous active-low reset (clears data and valid)
//   we         : this lane is the write target this cycle
//   clr_vld    : drop a held valid flag (frame alignment), hold mode only
//   pulse_mode : 1 = valid is a one-cycle pulse per write, 0 = valid holds
//   d          : word to capture
//   q / vld    : registered lane data and valid
// ---------------------------------------------------------------------------
module demux_lane_reg #(
   parameter int WIDTH = 4
) (
   input  logic             clk_4f,
   input  logic             reset_L,
   input  logic             we,
   input  logic             clr_vld,
   input  logic             pulse_mode,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic             vld
);

   // Lane register stage: data only changes on its own write.
   always_ff @(posedge clk_4f) begin
      if (!reset_L) begin
         q   <= '0;
         vld <= 1'b0;
      end else begin
         if (we) q <= d;
         // A write on the same cycle as an align wins over the clear.
         if (pulse_mode)   vld <= we;
         else if (we)      vld <= 1'b1;
         else if (clr_vld) vld <= 1'b0;
      end
   end

endmodule

// File: rtl/demux1an_rr_param.sv
// ---------------------------------------------------------------------------
// demux1an_rr_param
// Round-robin 1-to-LANES demultiplexer for the PHY receive path. Every valid
// input word goes to the current lane, then the lane pointer advances and
// wraps. align_in restarts the frame at lane 0. All outputs are registered,
// one cycle of latency, no backpressure.
//   clk_4f  : clock, rising edge
//   reset_L : synchronous active-low reset
//   bus     : demux1an_rr_param_if.slave (valid_in, data_in, align_in in;
//             data_out, valid_out, lane_ptr, frame_done out)
// Parameters: WIDTH word width, LANES lane count, HOLD_VALID lane-valid mode
// (VALID_HOLD / VALID_PULSE).
// ---------------------------------------------------------------------------
module demux1an_rr_param
   import phy_pkg::*;
#(
   parameter int WIDTH      = PHY_DATA_W,
   parameter int LANES      = 2,
   parameter int HOLD_VALID = VALID_HOLD
) (
   input  logic                 clk_4f,
   input  logic                 reset_L,
   demux1an_rr_param_if.slave   bus
);

   localparam int               PTR_W     = ptr_width(LANES);
   localparam logic [PTR_W-1:0] LAST_LANE = PTR_W'(LANES - 1);
   localparam logic             PULSE     = (HOLD_VALID == VALID_PULSE);

   logic [PTR_W-1:0]       ptr_p1;
   logic                   frame_done_p1;
   logic [PTR_W-1:0]       tgt_p0;
   logic                   tgt_last_p0;
   logic [LANES-1:0]       we_p0;
   logic [LANES*WIDTH-1:0] data_p1;
   logic [LANES-1:0]       vld_p1;

   // Input decode: align redirects this cycle's word to lane 0.
   assign tgt_p0      = bus.align_in ? '0 : ptr_p1;
   assign tgt_last_p0 = (tgt_p0 == LAST_LANE);

   always_comb begin
      we_p0 = '0;
      for (int i = 0; i < LANES; i++) begin
         we_p0[i] = bus.valid_in && (tgt_p0 == PTR_W'(i));
      end
   end

   // Register stage: pointer, frame pulse and lane registers.
   always_ff @(posedge clk_4f) begin
      if (!reset_L) begin
         ptr_p1        <= '0;
         frame_done_p1 <= 1'b0;
      end else begin
         frame_done_p1 <= bus.valid_in && tgt_last_p0;
         if (bus.valid_in)
            ptr_p1 <= tgt_last_p0 ? '0 : tgt_p0 + PTR_W'(1);
         else if (bus.align_in)
            ptr_p1 <= '0;
      end
   end

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      demux_lane_reg #(
         .WIDTH (WIDTH)
      ) u_lane (
         .clk_4f     (clk_4f),
         .reset_L    (reset_L),
         .we         (we_p0[g]),
         .clr_vld    (bus.align_in),
         .pulse_mode (PULSE),
         .d          (bus.data_in),
         .q          (data_p1[g*WIDTH +: WIDTH]),
         .vld        (vld_p1[g])
      );
   end

   assign bus.data_out   = data_p1;
   assign bus.valid_out  = vld_p1;
   assign bus.lane_ptr   = ptr_p1;
   assign bus.frame_done = frame_done_p1;

endmodule

// File: tb/tb_demux1an_rr_param.sv
// ---------------------------------------------------------------------------
// tb_demux1an_rr_param
// Four demux builds share one stimulus stream:
//   k=0: LANES=2 hold, k=1: LANES=4 hold, k=2: LANES=4 pulse, k=3: LANES=1 hold
// A frame-level model (word arrays, integer pointer modulo LANES) predicts
// every output of every build after each clock; directed steps add fixed
// expected values for the listed scenarios, then a random phase follows.
// ---------------------------------------------------------------------------
module tb_demux1an_rr_param;
   import phy_pkg::*;

   logic clk_4f = 1'b0;
   logic reset_L;
   always #5 clk_4f = ~clk_4f;

   demux1an_rr_param_if #(.WIDTH(4), .LANES(2)) i2  ();
   demux1an_rr_param_if #(.WIDTH(4), .LANES(4)) i4h ();
   demux1an_rr_param_if #(.WIDTH(4), .LANES(4)) i4p ();
   demux1an_rr_param_if #(.WIDTH(4), .LANES(1)) i1  ();

   demux1an_rr_param #(.WIDTH(4), .LANES(2), .HOLD_VALID(VALID_HOLD))
      dut2  (.clk_4f(clk_4f), .reset_L(reset_L), .bus(i2));
   demux1an_rr_param #(.WIDTH(4), .LANES(4), .HOLD_VALID(VALID_HOLD))
      dut4h (.clk_4f(clk_4f), .reset_L(reset_L), .bus(i4h));
   demux1an_rr_param #(.WIDTH(4), .LANES(4), .HOLD_VALID(VALID_PULSE))
      dut4p (.clk_4f(clk_4f), .reset_L(reset_L), .bus(i4p));
   demux1an_rr_param #(.WIDTH(4), .LANES(1), .HOLD_VALID(VALID_HOLD))
      dut1  (.clk_4f(clk_4f), .reset_L(reset_L), .bus(i1));

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state
   int       nl [4] = '{2, 4, 4, 1};
   bit       hv [4] = '{1, 1, 0, 1};
   int       m_ptr [4];
   logic [3:0] m_dat [4][4];
   logic [3:0] m_vld [4];
   logic       m_fd  [4];

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      assert (act === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic void model_step(input logic r, input logic v,
                                      input logic [3:0] d, input logic a);
      for (int k = 0; k < 4; k++) begin
         if (!r) begin
            m_ptr[k] = 0;
            m_vld[k] = '0;
            m_fd[k]  = 1'b0;
            for (int j = 0; j < 4; j++) m_dat[k][j] = '0;
         end else if (v) begin
            int t;
            t = a ? 0 : m_ptr[k];
            m_dat[k][t] = d;
            if (hv[k]) begin
               if (a) m_vld[k] = '0;
               m_vld[k][t] = 1'b1;
            end else begin
               m_vld[k] = 4'(1 << t);
            end
            m_ptr[k] = (t + 1) % nl[k];
            m_fd[k]  = (t == nl[k] - 1);
         end else begin
            if (a) m_ptr[k] = 0;
            if (a && hv[k]) m_vld[k] = '0;
            if (!hv[k]) m_vld[k] = '0;
            m_fd[k] = 1'b0;
         end
      end
   endfunction

   task automatic check_all();
      logic [15:0] ad [4];
      logic [3:0]  av [4];
      logic [31:0] ap [4];
      logic        af [4];
      ad[0] = 16'(i2.data_out);  av[0] = 4'(i2.valid_out);  ap[0] = 32'(i2.lane_ptr);  af[0] = i2.frame_done;
      ad[1] = i4h.data_out;      av[1] = i4h.valid_out;     ap[1] = 32'(i4h.lane_ptr); af[1] = i4h.frame_done;
      ad[2] = i4p.data_out;      av[2] = i4p.valid_out;     ap[2] = 32'(i4p.lane_ptr); af[2] = i4p.frame_done;
      ad[3] = 16'(i1.data_out);  av[3] = 4'(i1.valid_out);  ap[3] = 32'(i1.lane_ptr);  af[3] = i1.frame_done;
      for (int k = 0; k < 4; k++) begin
         logic [15:0] ed;
         ed = '0;
         for (int j = 0; j < nl[k]; j++) ed[j*4 +: 4] = m_dat[k][j];
         chk($sformatf("k%0d data_out", k),   32'(ad[k]), 32'(ed));
         chk($sformatf("k%0d valid_out", k),  32'(av[k]), 32'(m_vld[k]));
         chk($sformatf("k%0d lane_ptr", k),   ap[k],      32'(m_ptr[k]));
         chk($sformatf("k%0d frame_done", k), 32'(af[k]), 32'(m_fd[k]));
      end
   endtask

   task automatic set_in(input logic r, input logic v, input logic [3:0] d, input logic a);
      reset_L = r;
      i2.valid_in  = v; i2.data_in  = d; i2.align_in  = a;
      i4h.valid_in = v; i4h.data_in = d; i4h.align_in = a;
      i4p.valid_in = v; i4p.data_in = d; i4p.align_in = a;
      i1.valid_in  = v; i1.data_in  = d; i1.align_in  = a;
   endtask

   // One clock: drive, let the edge sample, update model, check on the falling edge.
   task automatic cyc(input logic r, input logic v, input logic [3:0] d, input logic a);
      set_in(r, v, d, a);
      @(posedge clk_4f);
      model_step(r, v, d, a);
      @(negedge clk_4f);
      check_all();
   endtask

   initial begin
      logic [3:0] p2_words [4] = '{4'hA, 4'h5, 4'h3, 4'hC};
      int         p2_ptr   [4] = '{1, 0, 1, 0};
      int         p2_fd    [4] = '{0, 1, 0, 1};
      int         p5_vld   [4] = '{'b0001, 'b0010, 'b0100, 'b1000};

      set_in(1'b0, 1'b0, 4'h0, 1'b0);
      model_step(1'b0, 1'b0, 4'h0, 1'b0);

      // Reset held with a valid word present
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 4'hF, 1'b0);
      chk("p1 data_out", 32'(i2.data_out), 0);
      chk("p1 lane_ptr", 32'(i2.lane_ptr), 0);
      chk("p1 valid_out", 32'(i2.valid_out), 0);

      // Two-lane alternation
      for (int i = 0; i < 4; i++) begin
         cyc(1'b1, 1'b1, p2_words[i], 1'b0);
         chk($sformatf("p2 ptr%0d", i), 32'(i2.lane_ptr), p2_ptr[i]);
         chk($sformatf("p2 fd%0d", i), 32'(i2.frame_done), p2_fd[i]);
         if (i == 0) chk("p2 lane0 A", 32'(i2.data_out[3:0]), 'hA);
         if (i == 1) chk("p2 lane1 5", 32'(i2.data_out[7:4]), 'h5);
      end
      chk("p2 final", 32'(i2.data_out), 'hC3);

      // Idle hold
      cyc(1'b0, 1'b0, 4'h0, 1'b0);
      cyc(1'b1, 1'b1, 4'h1, 1'b0);
      cyc(1'b1, 1'b1, 4'h2, 1'b0);
      for (int i = 0; i < 5; i++) begin
         cyc(1'b1, 1'b0, 4'h0, 1'b0);
         chk("p3 fd", 32'(i4h.frame_done), 0);
      end
      chk("p3 valid_out", 32'(i4h.valid_out), 'b0011);
      chk("p3 lane_ptr", 32'(i4h.lane_ptr), 2);
      chk("p3 data_out", 32'(i4h.data_out), 'h0021);

      // Align mid-frame
      cyc(1'b0, 1'b0, 4'h0, 1'b0);
      cyc(1'b1, 1'b1, 4'h7, 1'b0);
      cyc(1'b1, 1'b1, 4'h8, 1'b0);
      chk("p4 ptr before", 32'(i4h.lane_ptr), 2);
      cyc(1'b1, 1'b1, 4'h9, 1'b1);
      chk("p4 lane0", 32'(i4h.data_out[3:0]), 'h9);
      chk("p4 lane_ptr", 32'(i4h.lane_ptr), 1);
      chk("p4 valid_out", 32'(i4h.valid_out), 'b0001);

      // Pulse mode
      cyc(1'b0, 1'b0, 4'h0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         cyc(1'b1, 1'b1, 4'(i + 1), 1'b0);
         chk($sformatf("p5 vld%0d", i), 32'(i4p.valid_out), p5_vld[i]);
         chk($sformatf("p5 fd%0d", i), 32'(i4p.frame_done), (i == 3) ? 1 : 0);
      end
      cyc(1'b1, 1'b0, 4'h0, 1'b0);
      chk("p5 vld idle", 32'(i4p.valid_out), 0);
      chk("p5 data", 32'(i4p.data_out), 'h4321);

      // Reset mid-operation
      cyc(1'b0, 1'b0, 4'h0, 1'b0);
      cyc(1'b1, 1'b1, 4'h3, 1'b0);
      cyc(1'b1, 1'b1, 4'h4, 1'b0);
      cyc(1'b1, 1'b1, 4'h5, 1'b0);
      cyc(1'b0, 1'b0, 4'h0, 1'b0);
      chk("p6 rst data", 32'(i4h.data_out), 0);
      chk("p6 rst valid", 32'(i4h.valid_out), 0);
      chk("p6 rst ptr", 32'(i4h.lane_ptr), 0);
      cyc(1'b1, 1'b1, 4'hE, 1'b0);
      chk("p6 data", 32'(i4h.data_out), 'h000E);
      chk("p6 lane_ptr", 32'(i4h.lane_ptr), 1);
      chk("p6 one-lane fd", 32'(i1.frame_done), 1);

      // Random traffic with occasional align and reset
      for (int i = 0; i < 400; i++) begin
         cyc(($urandom_range(0, 39) != 0), ($urandom_range(0, 3) != 0),
             4'($urandom), ($urandom_range(0, 7) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/demux1an_rr_param.md
Name: demux1an_rr_param

Overview:
Parametrised round-robin 1-to-N demultiplexer for the PHY receive path. It is the generalised successor of the fixed 1-to-2, 4-bit receive demux.
- Each valid input word is steered to the current lane, then the lane pointer advances.
- Adds an alignment input, selectable valid-hold mode, a frame-complete pulse and a current-lane status output.
- Sits between the serial-to-parallel stage and the per-lane FIFOs. All outputs are registered.

Parameters:
WIDTH, 4, data word width in bits (>=1)
LANES, 2, number of output lanes N (>=1)
HOLD_VALID, 1, 1: lane valid stays set once written until reset/align; 0: lane valid is a one-cycle pulse per write
PTR_W, max(1,clog2(LANES)), lane pointer width (derived, not overridden)

Ports:
clk_4f  in  1  single clock; all state on rising edge
reset_L  in  1  synchronous, active-low reset, sampled on clk_4f rising edge
valid_in  in  1  data_in is a valid word this cycle
data_in  in  WIDTH  input word
align_in  in  1  force lane pointer to 0 (frame start)
data_out  out  LANES*WIDTH  lane i occupies bits [i*WIDTH +: WIDTH]
valid_out  out  LANES  per-lane valid
lane_ptr  out  PTR_W  lane that the next valid word will be written to
frame_done  out  1  one-cycle pulse: a word was written to lane LANES-1

Behaviour:
- Reset (reset_L=0 at clock edge):
  - data_out=0, valid_out=0, lane_ptr=0, frame_done=0.
  - Reset overrides valid_in and align_in.
  - Reset mid-frame discards the pointer position; no partial-frame flag is kept.
- Write, at an edge with reset_L=1 and valid_in=1:
  - Target lane t = (align_in ? 0 : lane_ptr).
  - data_out[t] <= data_in. All other lanes hold their previous data. Data is never cleared except by reset.
  - Latency is 1: the word is visible on data_out at the edge after it was sampled.
  - lane_ptr <= (t==LANES-1) ? 0 : t+1. The pointer wraps modulo LANES.
  - frame_done <= (t==LANES-1).
- Idle (valid_in=0):
  - data_out and lane_ptr hold.
  - If align_in=1, lane_ptr <= 0.
  - frame_done <= 0.
- Valid, HOLD_VALID=1:
  - valid_out[t] <= 1 on a write; other bits hold.
  - align_in=1 clears all bits except the one being written this same cycle.
- Valid, HOLD_VALID=0:
  - valid_out <= one-hot(t) on a write, otherwise 0.
  - align_in has no extra effect on valid_out.
- LANES=1: pointer is constant 0, every write goes to lane 0, and frame_done pulses on every write.
- Back-to-back valid words are accepted every cycle. There is no backpressure and no word is dropped.
- No combinational path from any input to any output.
- State: lane pointer only. There is no separate FSM; the pointer acts as an N-state cyclic machine (LANE_0..LANE_N-1, advance on valid, jump to LANE_0 on align).

Decomposition:
- Shared package phy_pkg holds:
  - clog2 helper function
  - HOLD_VALID mode constants (VALID_PULSE=0, VALID_HOLD=1)
  - default PHY data width constant (4)
- Sub-module demux_lane_reg:
  - one lane's WIDTH-bit data register plus valid bit
  - inputs: write-enable, clear-valid, pulse-mode
  - instantiated LANES times with a generate loop
- The top holds the pointer, target decode, and frame_done.

Test Plan:
1. Reset: LANES=2, WIDTH=4; hold reset_L=0 for 3 cycles with valid_in=1, data_in=4'hF -> all outputs stay 0, lane_ptr=0.
2. Alternation: LANES=2; stream 4'hA,4'h5,4'h3,4'hC on consecutive cycles ->
   - lane0 takes A then 3; lane1 takes 5 then C, each 1 cycle after input.
   - lane_ptr toggles 1,0,1,0.
   - frame_done pulses after 5 and after C.
3. Idle hold: LANES=4, HOLD_VALID=1; write 1,2; then valid_in=0 for 5 cycles ->
   - data_out lanes 0/1 = 1/2 held; valid_out=4'b0011; lane_ptr=2 stable.
   - No frame_done.
4. Align mid-frame: LANES=4; write 7,8 (ptr=2); then align_in=1 with valid_in=1, data 9 ->
   - lane0=9, lane_ptr=1.
   - HOLD_VALID=1: valid_out=4'b0001.
5. Pulse mode: LANES=4, HOLD_VALID=0; write words 1,2,3,4 back-to-back ->
   - valid_out = 0001,0010,0100,1000 on successive cycles, then 0000.
   - frame_done on the 4th.
6. Reset mid-operation: LANES=4; write 3 words, then reset_L=0 for 1 cycle, then write E ->
   - after reset all outputs are 0; E lands in lane0; lane_ptr=1.
